// File: rtl/pq_sched.sv
// pq_sched: round-robin front end that arbitrates N_REQ requesters onto a
// single priority queue, and drains that queue on request.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   req_valid/op/key/val     per-requester requests (op 1 = REPLACE, 0 = DEQ)
//   req_ready                one-hot grant (combinational)
//   rsp_valid/id/key/val/err registered response, one cycle after each grant
//   flush_req, flush_done    drain request (level) and completion pulse
//   pq_replace, pq_deq, pq_kvi  queue command strobes and payload (combinational)
//   pq_kvo, pq_busy, pq_empty   queue head {key, value} and status
module pq_sched #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned KW    = 16,
   parameter int unsigned VW    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ-1:0]    req_op,
   input  logic [N_REQ*KW-1:0] req_key,
   input  logic [N_REQ*VW-1:0] req_val,
   output logic [N_REQ-1:0]    req_ready,
   output logic                rsp_valid,
   output logic [2:0]          rsp_id,
   output logic [KW-1:0]       rsp_key,
   output logic [VW-1:0]       rsp_val,
   output logic                rsp_err,
   input  logic                flush_req,
   output logic                flush_done,
   output logic                pq_replace,
   output logic                pq_deq,
   output logic [KW+VW-1:0]    pq_kvi,
   input  logic [KW+VW-1:0]    pq_kvo,
   input  logic                pq_busy,
   input  logic                pq_empty
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {ARB, FLUSH} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [PW-1:0]   ptr_nxt;
   logic [PW:0]     cand;
   logic            found;
   logic            grant;
   logic            rej;
   logic [KW-1:0]   keys [N_REQ];
   logic [VW-1:0]   vals [N_REQ];
   logic [KW-1:0]   win_key;
   logic [VW-1:0]   win_val;
   logic            win_op;
   logic            key_bad;

   // Unpack the flat request buses.
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         keys[k] = req_key[k*KW +: KW];
         vals[k] = req_val[k*VW +: VW];
      end
   end

   // Round-robin search: first valid requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr} + (PW+1)'(k);
         if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
         if (!found && req_valid[cand[PW-1:0]]) begin
            found = 1'b1;
            win   = cand[PW-1:0];
         end
      end
   end

   assign win_key = keys[win];
   assign win_val = vals[win];
   assign win_op  = req_op[win];
   // Both extreme keys are reserved sentinels and may not enter the queue.
   assign key_bad = (win_key == {KW{1'b1}}) || (win_key == {KW{1'b0}});
   assign ptr_nxt = (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);

   // Next state and combinational queue/grant outputs; all quiet in reset.
   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      pq_replace = 1'b0;
      pq_deq     = 1'b0;
      pq_kvi     = '0;
      flush_done = 1'b0;
      grant      = 1'b0;
      rej        = 1'b0;
      if (rst) begin
         case (state_q)
            ARB: begin
               if (flush_req) begin
                  state_d = FLUSH;
               end else if (!pq_busy && found) begin
                  grant     = 1'b1;
                  req_ready = N_REQ'(1) << win;
                  if (win_op) begin
                     if (key_bad) begin
                        rej = 1'b1;
                     end else begin
                        pq_replace = 1'b1;
                        pq_kvi     = {win_key, win_val};
                     end
                  end else if (pq_empty) begin
                     rej = 1'b1;
                  end else begin
                     pq_deq = 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (!pq_busy) begin
                  if (pq_empty) begin
                     flush_done = 1'b1;
                     state_d    = ARB;
                  end else begin
                     pq_deq = 1'b1;
                  end
               end
            end
            default: state_d = ARB;
         endcase
      end
   end

   // State, pointer and response registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ARB;
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_id    <= '0;
         rsp_key   <= '0;
         rsp_val   <= '0;
      end else begin
         state_q   <= state_d;
         if (grant) ptr <= ptr_nxt;
         rsp_valid <= grant;
         rsp_err   <= rej;
         rsp_id    <= grant ? 3'(win) : 3'd0;
         // An empty-queue DEQ reports the KEYINF sentinel instead of the head.
         if (!grant)
            rsp_key <= '0;
         else if (rej && !win_op)
            rsp_key <= {KW{1'b1}};
         else
            rsp_key <= pq_kvo[KW+VW-1:VW];
         rsp_val   <= grant ? pq_kvo[VW-1:0] : '0;
      end
   end

endmodule

// File: tb/tb_pq_sched.sv
// Directed bench for pq_sched (N_REQ=4, KW=VW=16).
module tb_pq_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_op;
   logic [63:0] req_key;
   logic [63:0] req_val;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [2:0]  rsp_id;
   logic [15:0] rsp_key;
   logic [15:0] rsp_val;
   logic        rsp_err;
   logic        flush_req;
   logic        flush_done;
   logic        pq_replace;
   logic        pq_deq;
   logic [31:0] pq_kvi;
   logic [31:0] pq_kvo;
   logic        pq_busy;
   logic        pq_empty;

   int total = 0;
   int bad   = 0;

   pq_sched #(.N_REQ(4), .KW(16), .VW(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op(req_op), .req_key(req_key), .req_val(req_val),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_key(rsp_key), .rsp_val(rsp_val),
      .rsp_err(rsp_err),
      .flush_req(flush_req), .flush_done(flush_done),
      .pq_replace(pq_replace), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
      .pq_kvo(pq_kvo), .pq_busy(pq_busy), .pq_empty(pq_empty)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are changed here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = '0; req_op = '0; req_key = '0; req_val = '0;
      flush_req = 0; pq_busy = 0;
   endtask

   task automatic test_reset();
      rst = 0; idle_inputs();
      req_valid = 4'hF; pq_empty = 0; pq_kvo = 32'h0009_1234;
      tick(); tick(); #1;
      total++; if (req_ready !== 4'b0000) begin $display("FAIL reset_ready got=%b exp=0000", req_ready); bad++; end
      total++; if (pq_deq !== 1'b0) begin $display("FAIL reset_deq got=%b exp=0", pq_deq); bad++; end
      total++; if (rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); bad++; end
      total++; if (rsp_key !== 16'h0 || rsp_id !== 3'd0) begin $display("FAIL reset_rsp_fields got key=%h id=%0d exp 0/0", rsp_key, rsp_id); bad++; end
      total++; if (flush_done !== 1'b0) begin $display("FAIL reset_flush_done got=%b exp=0", flush_done); bad++; end
      tick(); rst = 1; req_valid = '0;
   endtask

   // All four hold DEQ: grants 0,1,2,3,0 with responses one cycle later.
   task automatic test_round_robin();
      int exp_id [5] = '{0, 1, 2, 3, 0};
      tick();
      req_valid = 4'hF; req_op = 4'h0; pq_empty = 0; pq_kvo = 32'h0009_1234;
      for (int c = 0; c < 5; c++) begin
         #1;
         total++; if (req_ready !== (4'b0001 << exp_id[c])) begin $display("FAIL rr_grant c=%0d got=%b exp_id=%0d", c, req_ready, exp_id[c]); bad++; end
         total++; if (pq_deq !== 1'b1 || pq_replace !== 1'b0) begin $display("FAIL rr_strobe c=%0d got deq=%b rep=%b exp 1/0", c, pq_deq, pq_replace); bad++; end
         if (c > 0) begin
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 3'(exp_id[c-1])) begin $display("FAIL rr_rsp c=%0d got v=%b id=%0d exp 1/%0d", c, rsp_valid, rsp_id, exp_id[c-1]); bad++; end
         end
         tick();
      end
      req_valid = '0; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_key !== 16'h0009 || rsp_val !== 16'h1234) begin $display("FAIL rr_last_rsp got v=%b id=%0d key=%h val=%h exp 1/0/0009/1234", rsp_valid, rsp_id, rsp_key, rsp_val); bad++; end
      total++; if (req_ready !== 4'b0000) begin $display("FAIL rr_idle_ready got=%b exp=0000", req_ready); bad++; end
      tick();
      total++; if (rsp_valid !== 1'b0) begin $display("FAIL rr_idle_rsp got=%b exp=0", rsp_valid); bad++; end
   endtask

   // ptr=1: requester 2 REPLACE key 0005 against head key 0009.
   task automatic test_replace();
      req_valid = 4'b0100; req_op = 4'b0100;
      req_key = 64'h0000_0005_0000_0000; req_val = 64'h0000_ABCD_0000_0000;
      pq_kvo = 32'h0009_7777; pq_empty = 0; #1;
      total++; if (req_ready !== 4'b0100) begin $display("FAIL rep_grant got=%b exp=0100", req_ready); bad++; end
      total++; if (pq_replace !== 1'b1 || pq_deq !== 1'b0) begin $display("FAIL rep_strobe got rep=%b deq=%b exp 1/0", pq_replace, pq_deq); bad++; end
      total++; if (pq_kvi !== 32'h0005_ABCD) begin $display("FAIL rep_kvi got=%h exp=0005abcd", pq_kvi); bad++; end
      tick(); req_valid = '0; req_op = '0; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_err !== 1'b0) begin $display("FAIL rep_rsp got v=%b id=%0d err=%b exp 1/2/0", rsp_valid, rsp_id, rsp_err); bad++; end
      total++; if (rsp_key !== 16'h0009 || rsp_val !== 16'h7777) begin $display("FAIL rep_rsp_kv got=%h/%h exp=0009/7777", rsp_key, rsp_val); bad++; end
      tick();
   endtask

   // ptr=3: empty DEQ from 3, then REPLACE key 0000 from 0, key FFFF from 1.
   task automatic test_errors();
      req_valid = 4'b1000; req_op = 4'b0000; pq_empty = 1; pq_kvo = 32'h0000_0000; #1;
      total++; if (req_ready !== 4'b1000 || pq_deq !== 1'b0) begin $display("FAIL err_empty_issue got ready=%b deq=%b exp 1000/0", req_ready, pq_deq); bad++; end
      tick(); pq_empty = 0; pq_kvo = 32'h0009_1111;
      req_valid = 4'b0001; req_op = 4'b0001; req_key = 64'h0; req_val = 64'h0000_0000_0000_2222; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_key !== 16'hFFFF || rsp_id !== 3'd3) begin $display("FAIL err_empty_rsp got v=%b err=%b key=%h id=%0d exp 1/1/ffff/3", rsp_valid, rsp_err, rsp_key, rsp_id); bad++; end
      total++; if (req_ready !== 4'b0001 || pq_replace !== 1'b0 || pq_deq !== 1'b0) begin $display("FAIL err_key0_issue got ready=%b rep=%b deq=%b exp 0001/0/0", req_ready, pq_replace, pq_deq); bad++; end
      tick();
      req_valid = 4'b0010; req_op = 4'b0010; req_key = 64'h0000_0000_FFFF_0000; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 3'd0) begin $display("FAIL err_key0_rsp got v=%b err=%b id=%0d exp 1/1/0", rsp_valid, rsp_err, rsp_id); bad++; end
      total++; if (req_ready !== 4'b0010 || pq_replace !== 1'b0) begin $display("FAIL err_keyinf_issue got ready=%b rep=%b exp 0010/0", req_ready, pq_replace); bad++; end
      tick(); req_valid = '0; req_op = '0; req_key = '0; #1;
      total++; if (rsp_err !== 1'b1 || rsp_id !== 3'd1) begin $display("FAIL err_keyinf_rsp got err=%b id=%0d exp 1/1", rsp_err, rsp_id); bad++; end
      tick();
   endtask

   // ptr=2: busy for 3 cycles blocks everything, then grant goes to 2.
   task automatic test_busy();
      req_valid = 4'hF; req_op = 4'h0; pq_empty = 0; pq_busy = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (req_ready !== 4'b0000 || pq_deq !== 1'b0 || pq_replace !== 1'b0) begin $display("FAIL busy_hold c=%0d got ready=%b deq=%b rep=%b exp 0", c, req_ready, pq_deq, pq_replace); bad++; end
         total++; if (rsp_valid !== 1'b0) begin $display("FAIL busy_rsp c=%0d got=%b exp=0", c, rsp_valid); bad++; end
         tick();
      end
      pq_busy = 0; #1;
      total++; if (req_ready !== 4'b0100 || pq_deq !== 1'b1) begin $display("FAIL busy_resume got ready=%b deq=%b exp 0100/1", req_ready, pq_deq); bad++; end
      tick(); req_valid = '0; tick();
   endtask

   // ptr=3: flush with 3 queued items while everyone requests.
   task automatic test_flush();
      int items = 3;
      int deqs  = 0;
      int dones = 0;
      int rsps  = 0;
      int grants = 0;
      req_valid = 4'hF; req_op = 4'h0; pq_empty = 0; flush_req = 1; #1;
      total++; if (req_ready !== 4'b0000 || pq_deq !== 1'b0) begin $display("FAIL flush_entry got ready=%b deq=%b exp 0000/0", req_ready, pq_deq); bad++; end
      tick(); flush_req = 0;
      for (int c = 0; c < 20 && dones == 0; c++) begin
         pq_empty = (items == 0); #1;
         if (req_ready !== 4'b0000) grants++;
         if (rsp_valid !== 1'b0) rsps++;
         if (pq_deq === 1'b1) begin deqs++; if (items > 0) items--; end
         if (flush_done === 1'b1) dones++;
         tick();
      end
      #1;
      total++; if (deqs !== 3) begin $display("FAIL flush_deq_count got=%0d exp=3", deqs); bad++; end
      total++; if (dones !== 1) begin $display("FAIL flush_done_count got=%0d exp=1", dones); bad++; end
      total++; if (rsps !== 0 || grants !== 0) begin $display("FAIL flush_quiet got rsp=%0d grants=%0d exp 0/0", rsps, grants); bad++; end
      total++; if (req_ready !== 4'b1000 || flush_done !== 1'b0) begin $display("FAIL flush_back_arb got ready=%b done=%b exp 1000/0", req_ready, flush_done); bad++; end
      tick(); req_valid = '0; pq_empty = 0; tick();
   endtask

   // ptr=0 -> grant 2 (ptr=3), then reset in a grant cycle; ptr returns to 0.
   task automatic test_reset_grant();
      req_valid = 4'b0100; req_op = 4'h0; pq_empty = 0; #1;
      total++; if (req_ready !== 4'b0100) begin $display("FAIL rstg_pre got=%b exp=0100", req_ready); bad++; end
      tick(); req_valid = 4'b1000; rst = 0; #1;
      total++; if (req_ready !== 4'b0000 || pq_deq !== 1'b0) begin $display("FAIL rstg_during got ready=%b deq=%b exp 0000/0", req_ready, pq_deq); bad++; end
      tick(); rst = 1; req_valid = 4'hF; #1;
      total++; if (rsp_valid !== 1'b0) begin $display("FAIL rstg_no_rsp got=%b exp=0", rsp_valid); bad++; end
      total++; if (req_ready !== 4'b0001) begin $display("FAIL rstg_first_grant got=%b exp=0001", req_ready); bad++; end
      tick(); req_valid = '0; #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0) begin $display("FAIL rstg_rsp got v=%b id=%0d exp 1/0", rsp_valid, rsp_id); bad++; end
      tick();
   endtask

   initial begin
      rst = 0; pq_empty = 1; pq_kvo = '0; idle_inputs();
      test_reset();
      test_round_robin();
      test_replace();
      test_errors();
      test_busy();
      test_flush();
      test_reset_grant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
